reg_file: RTL and testbench
===========================

# reg_file

Y86-64 SEQ register file, directly downstream of the write-back destination selector. Holds the 15 program registers (%rax..%r14). Provides two combinational read ports for decode (srcA/srcB → valA/valB). Commits up to two results per clock (valE to dstE, valM to dstM), gated by the conditional-move flag and the processor status, and latches a sticky halt flag.

## Interface
Parameters:
- DATA_W, 64, register and data width
- NREG, 15, number of architectural registers; ID 15 (RNONE) means no register

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset, sampled on clk rising edge
- icode  in  4  icode of the instruction in write-back
- cnd  in  1  condition result from execute
- stat  in  3  instruction status: 1=AOK, 2=HLT, 3=ADR, 4=INS
- srcA  in  4  read port A register ID
- srcB  in  4  read port B register ID
- valA  out  DATA_W  read data A; 0 when srcA==15
- valB  out  DATA_W  read data B; 0 when srcB==15
- dstE  in  4  E-port destination ID; 15 = no write
- valE  in  DATA_W  E-port write data
- dstM  in  4  M-port destination ID; 15 = no write
- valM  in  DATA_W  M-port write data
- halted  out  1  sticky halt flag

## Operation
- Storage: NREG × DATA_W flops, indexed 0..14. ID 15 is never stored.
- Read ports are purely combinational from storage.
  - Without bypass: a same-cycle write is visible only after the edge.
- E-port write enable (we_E) requires all of:
  - dstE != 15
  - stat == AOK
  - halted == 0
  - NOT (icode == 2 AND cnd == 0); a failed cmovXX suppresses only the E write.
- M-port write enable (we_M) requires all of:
  - dstM != 15
  - stat == AOK
  - halted == 0
- Port conflict: if dstE == dstM and both ports are enabled, valM is written (popq %rsp semantics).
- Halt: at any edge where stat != AOK and halted == 0, set halted = 1. That instruction's writes are suppressed.
- While halted == 1, all writes are blocked; only reset clears halted.

## Timing
- Read latency is 0 cycles (combinational). Write commits on the clk rising edge.
- Reset (rst_n == 0 at an edge): all registers = 0 and halted = 0. Reset overrides any same-cycle write or halt.
- Reset mid-program discards the pending write, and the state restarts from zeros.
- First edge with rst_n == 1 and AOK status performs normal writes.
- halted rises on the edge after the non-AOK stat is presented. It stays high through further AOK stat inputs.
- A write to ID 15 is a no-op in every mode. Reading ID 15 returns 0 in every mode.

## Configuration
- Macro REG_FILE_BYPASS_EN.
- Defined: read ports are write-through. If srcX matches an enabled write this cycle, valX returns the write data; valM takes priority over valE.
- Not defined: reads return stored (pre-edge) values only; there is no combinational path from valE/valM to valA/valB.
- Write enables, conflict rules, and the halt flag are identical in both modes.

## Structure
- Shared package holds:
  - RNONE = 4'hF
  - stat codes SAOK/SHLT/SADR/SINS
  - icode constants: IHALT=0, INOP=1, IRRMOVQ=2, IIRMOVQ=3, IRMMOVQ=4, IMRMOVQ=5, IOPQ=6, IJXX=7, ICALL=8, IRET=9, IPUSHQ=10, IPOPQ=11
  - DATA_W default
- One natural sub-module: reg_file_wen, combinational write-enable/priority logic producing we_E and we_M. Storage, read muxes, and the halt flop stay in the top level.

## Test plan
- Reset then read all IDs 0..15 → every valA/valB = 0, halted = 0.
- dstE=3, valE=0x1122334455667788, icode=6, stat=1, one edge; then srcA=3 → valA = 0x1122334455667788.
- icode=2, cnd=0, dstE=5, valE=0xAA → r5 stays 0. Repeat with cnd=1 → r5 = 0xAA.
- dstE=dstM=4, valE=0x10, valM=0x20, icode=11, stat=1 → r4 = 0x20.
- stat=2 with dstE=1, valE=0x55 → r1 unchanged and halted=1 after the edge. Then stat=1 with dstE=1 → r1 still unchanged. Assert rst_n=0 → halted=0 and all registers 0.
- Same-cycle write r7=0x99 with srcB=7:
  - With REG_FILE_BYPASS_EN → valB = 0x99 before the edge.
  - Without → valB = old value before the edge and 0x99 after it.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared constants for the Y86-64 SEQ register file: register IDs, status codes,
// instruction codes and the default data width.
package reg_file_pkg;

    localparam int DATA_W_DEF = 64;
    localparam int NREG_DEF   = 15;

    localparam logic [3:0] RNONE = 4'hF;

    typedef enum logic [2:0] {
        SAOK = 3'd1,
        SHLT = 3'd2,
        SADR = 3'd3,
        SINS = 3'd4
    } stat_e;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

endpackage

// File: rtl/reg_file_wen.sv
// Write-enable and port-priority logic for the register file. A failed cmovXX
// kills only the E write; on a dstE/dstM collision the M port wins.
module reg_file_wen
    import reg_file_pkg::*;
(
    input  logic [3:0] icode,
    input  logic       cnd,
    input  logic [2:0] stat,
    input  logic       halted,
    input  logic [3:0] dstE,
    input  logic [3:0] dstM,
    output logic       we_E,
    output logic       we_M
);

    logic commit_ok;
    logic e_raw;

    always_comb begin
        commit_ok = (stat == SAOK) && !halted;
        we_M      = commit_ok && (dstM != RNONE);
        e_raw     = commit_ok && (dstE != RNONE) && !((icode == IRRMOVQ) && !cnd);
        // Dropping E on a collision lets the storage and bypass paths stay simple.
        we_E      = e_raw && !(we_M && (dstE == dstM));
    end

endmodule

// File: rtl/reg_file.sv
// Y86-64 SEQ register file: 15 x DATA_W storage, two combinational read ports,
// two write ports and a sticky halt flag. Define REG_FILE_BYPASS_EN for write-through reads.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NREG   = NREG_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        icode,
    input  logic              cnd,
    input  logic [2:0]        stat,
    input  logic [3:0]        srcA,
    input  logic [3:0]        srcB,
    output logic [DATA_W-1:0] valA,
    output logic [DATA_W-1:0] valB,
    input  logic [3:0]        dstE,
    input  logic [DATA_W-1:0] valE,
    input  logic [3:0]        dstM,
    input  logic [DATA_W-1:0] valM,
    output logic              halted
);

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic              halted_q;
    logic              halted_d;
    logic              we_E;
    logic              we_M;

    reg_file_wen u_wen (
        .icode  (icode),
        .cnd    (cnd),
        .stat   (stat),
        .halted (halted_q),
        .dstE   (dstE),
        .dstM   (dstM),
        .we_E   (we_E),
        .we_M   (we_M)
    );

    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            regs_d[i] = regs_q[i];
            if (we_M && (dstM == 4'(i))) begin
                regs_d[i] = valM;
            end else if (we_E && (dstE == 4'(i))) begin
                regs_d[i] = valE;
            end
        end
        halted_d = halted_q || (stat != SAOK);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            halted_q <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
            halted_q <= halted_d;
        end
    end

    // ID 15 matches no storage entry and is never write-enabled, so it reads as 0.
    always_comb begin
        valA = '0;
        valB = '0;
        for (int i = 0; i < NREG; i++) begin
            if (srcA == 4'(i)) valA = regs_q[i];
            if (srcB == 4'(i)) valB = regs_q[i];
        end
`ifdef REG_FILE_BYPASS_EN
        if (srcA != RNONE) begin
            if (we_M && (dstM == srcA))      valA = valM;
            else if (we_E && (dstE == srcA)) valA = valE;
        end
        if (srcB != RNONE) begin
            if (we_M && (dstM == srcB))      valB = valM;
            else if (we_E && (dstE == srcB)) valB = valE;
        end
`endif
    end

    assign halted = halted_q;

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file; bypass expectations follow REG_FILE_BYPASS_EN.
module tb_reg_file;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   icode;
    logic         cnd;
    logic [2:0]   stat;
    logic [3:0]   srcA;
    logic [3:0]   srcB;
    logic [W-1:0] valA;
    logic [W-1:0] valB;
    logic [3:0]   dstE;
    logic [W-1:0] valE;
    logic [3:0]   dstM;
    logic [W-1:0] valM;
    logic         halted;

    int n_cmp = 0;
    int n_err = 0;

    reg_file dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .icode  (icode),
        .cnd    (cnd),
        .stat   (stat),
        .srcA   (srcA),
        .srcB   (srcB),
        .valA   (valA),
        .valB   (valB),
        .dstE   (dstE),
        .valE   (valE),
        .dstM   (dstM),
        .valM   (valM),
        .halted (halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        icode = 4'h1;
        cnd   = 1'b0;
        stat  = 3'd1;
        dstE  = 4'hF;
        valE  = '0;
        dstM  = 4'hF;
        valM  = '0;
    endtask

    task automatic drive_wr(input logic [3:0] ic, input logic c, input logic [2:0] st,
                            input logic [3:0] de, input logic [W-1:0] ve,
                            input logic [3:0] dm, input logic [W-1:0] vm);
        icode = ic;
        cnd   = c;
        stat  = st;
        dstE  = de;
        valE  = ve;
        dstM  = dm;
        valM  = vm;
    endtask

    task automatic read_a(input logic [3:0] id, input string tag, input logic [W-1:0] exp);
        srcA = id;
        #1;
        check(tag, valA, exp);
    endtask

    initial begin
        rst_n = 1'b0;
        srcA  = 4'h0;
        srcB  = 4'h0;
        idle();
        // Dirty write attempt during reset must not land.
        drive_wr(4'h6, 1'b0, 3'd1, 4'h2, 64'hFFFF, 4'hF, '0);
        step();
        idle();
        step();
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            srcA = 4'(i);
            srcB = 4'(15 - i);
            #1;
            check($sformatf("reset_valA_%0d", i), valA, '0);
            check($sformatf("reset_valB_%0d", 15 - i), valB, '0);
        end
        check("reset_halted", W'(halted), '0);

        drive_wr(4'h6, 1'b0, 3'd1, 4'h3, 64'h1122334455667788, 4'hF, '0);
        step();
        idle();
        read_a(4'h3, "opq_r3", 64'h1122334455667788);

        drive_wr(4'h2, 1'b0, 3'd1, 4'h5, 64'hAA, 4'hF, '0);
        step();
        idle();
        read_a(4'h5, "cmov_fail_r5", 64'h0);
        drive_wr(4'h2, 1'b1, 3'd1, 4'h5, 64'hAA, 4'hF, '0);
        step();
        idle();
        read_a(4'h5, "cmov_take_r5", 64'hAA);

        // A failed cmov kills only the E port; M still commits.
        drive_wr(4'h2, 1'b0, 3'd1, 4'h6, 64'hBB, 4'hA, 64'h1010);
        step();
        idle();
        read_a(4'h6, "cmov_fail_e_r6", 64'h0);
        read_a(4'hA, "cmov_fail_m_r10", 64'h1010);

        drive_wr(4'hB, 1'b0, 3'd1, 4'h4, 64'h10, 4'h4, 64'h20);
        step();
        idle();
        read_a(4'h4, "conflict_r4", 64'h20);

        drive_wr(4'hB, 1'b0, 3'd1, 4'h8, 64'h80, 4'h9, 64'h90);
        step();
        idle();
        read_a(4'h8, "dual_e_r8", 64'h80);
        read_a(4'h9, "dual_m_r9", 64'h90);

        drive_wr(4'h6, 1'b0, 3'd1, 4'hF, 64'hDEAD, 4'hF, 64'hBEEF);
        step();
        idle();
        read_a(4'hF, "rnone_read", 64'h0);
        read_a(4'hE, "rnone_r14", 64'h0);
        read_a(4'h3, "rnone_r3_kept", 64'h1122334455667788);

        srcB = 4'h7;
        drive_wr(4'h6, 1'b0, 3'd1, 4'h7, 64'h99, 4'hF, '0);
        #1;
`ifdef REG_FILE_BYPASS_EN
        check("same_cycle_valB_pre", valB, 64'h99);
`else
        check("same_cycle_valB_pre", valB, 64'h0);
`endif
        step();
        idle();
        #1;
        check("same_cycle_valB_post", valB, 64'h99);

        drive_wr(4'h6, 1'b0, 3'd2, 4'h1, 64'h55, 4'hF, '0);
        #1;
        check("halt_pre_edge", W'(halted), '0);
        step();
        idle();
        check("halt_set", W'(halted), 64'h1);
        read_a(4'h1, "halt_r1_blocked", 64'h0);
        drive_wr(4'h6, 1'b0, 3'd1, 4'h1, 64'h66, 4'h2, 64'h77);
        step();
        idle();
        check("halt_sticky", W'(halted), 64'h1);
        read_a(4'h1, "halted_r1_blocked", 64'h0);
        read_a(4'h2, "halted_r2_blocked", 64'h0);
        read_a(4'h3, "halted_r3_kept", 64'h1122334455667788);

        rst_n = 1'b0;
        drive_wr(4'h6, 1'b0, 3'd1, 4'h3, 64'h77, 4'hF, '0);
        step();
        rst_n = 1'b1;
        idle();
        #1;
        check("rst_halted_clr", W'(halted), '0);
        for (int i = 0; i < 16; i++) begin
            read_a(4'(i), $sformatf("rst2_r%0d", i), '0);
        end

        drive_wr(4'h3, 1'b0, 3'd1, 4'h0, 64'h1234, 4'hF, '0);
        step();
        idle();
        read_a(4'h0, "post_rst_write_r0", 64'h1234);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
